// File: rtl/subleq_mem_if.sv
// Word-memory port between the SUBLEQ sequencer (master) and a single-port memory (slave).
// load: read strobe, mem_out is valid combinationally in the same cycle; store: mem[addr] <= mem_in at the next posedge.
interface subleq_mem_if #(parameter int W = 8);
    logic         load;
    logic         store;
    logic [W-1:0] addr;
    logic [W-1:0] mem_in;
    logic [W-1:0] mem_out;

    modport master (output load, output store, output addr, output mem_in, input mem_out);
    modport slave  (input load, input store, input addr, input mem_in, output mem_out);
endinterface

// File: rtl/subleq_control.sv
// SUBLEQ sequencer: six one-cycle states per instruction (fetch A/B/C, read A/B, write-back and branch).
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module subleq_control #(
    parameter int           W         = `WORD_SIZE,
    parameter logic [W-1:0] START_PC  = '0,
    parameter logic [W-1:0] HALT_ADDR = '1
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic         start,
    input  logic         stop,
    subleq_mem_if.master mem,
    output logic [W-1:0] pc,
    output logic         busy,
    output logic         halted,
    output logic [W-1:0] icount,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_A, S_FETCH_B, S_FETCH_C, S_READ_A, S_READ_B, S_WRITE, S_HALT
    } state_t;

    state_t       state;
    logic [W-1:0] a, b, c, va, vb;
    logic         load_q, store_q;
    logic [W-1:0] addr_q, mem_in_q;
    logic [W-1:0] r, npc;
    logic         leq;

    // Branch decision uses the operand registers; only meaningful while in WRITE.
    assign r   = vb - va;
    assign leq = r[W-1] | (r == '0);
    assign npc = leq ? c : pc + W'(3);

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            state    <= S_IDLE;
            pc       <= START_PC;
            icount   <= '0;
            a        <= '0;
            b        <= '0;
            c        <= '0;
            va       <= '0;
            vb       <= '0;
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            addr_q   <= '0;
            mem_in_q <= '0;
        end else begin
            // Bus outputs are registered: each branch sets up the bus for the state it enters.
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            addr_q   <= '0;
            mem_in_q <= '0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state  <= S_FETCH_A;
                        pc     <= START_PC;
                        icount <= '0;
                        load_q <= 1'b1;
                        addr_q <= START_PC;
                    end
                end
                S_FETCH_A: begin
                    a      <= mem.mem_out;
                    state  <= S_FETCH_B;
                    load_q <= 1'b1;
                    addr_q <= pc + W'(1);
                end
                S_FETCH_B: begin
                    b      <= mem.mem_out;
                    state  <= S_FETCH_C;
                    load_q <= 1'b1;
                    addr_q <= pc + W'(2);
                end
                S_FETCH_C: begin
                    c      <= mem.mem_out;
                    state  <= S_READ_A;
                    load_q <= 1'b1;
                    addr_q <= a;
                end
                S_READ_A: begin
                    va     <= mem.mem_out;
                    state  <= S_READ_B;
                    load_q <= 1'b1;
                    addr_q <= b;
                end
                S_READ_B: begin
                    vb       <= mem.mem_out;
                    state    <= S_WRITE;
                    store_q  <= 1'b1;
                    addr_q   <= b;
                    mem_in_q <= mem.mem_out - va;
                end
                S_WRITE: begin
                    pc     <= npc;
                    icount <= icount + W'(1);
                    if (npc == HALT_ADDR || stop) begin
                        state <= S_HALT;
                    end else begin
                        state  <= S_FETCH_A;
                        load_q <= 1'b1;
                        addr_q <= npc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reset kills a write already on the bus, including one in progress.
    assign mem.load   = load_q;
    assign mem.store  = store_q & areset_n;
    assign mem.addr   = addr_q;
    assign mem.mem_in = mem_in_q;

    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign halted    = (state == S_HALT);
    assign dbg_state = state;

endmodule

// File: tb/tb_subleq_control.sv
// Bench for subleq_control: memory model, instruction-level reference model, directed and random runs.
module tb_subleq_control;
    localparam int W = 8;
    localparam logic [W-1:0] START_PC  = 8'h00;
    localparam logic [W-1:0] HALT_ADDR = 8'hFF;

    typedef struct packed {
        logic         load;
        logic         store;
        logic [W-1:0] addr;
        logic [W-1:0] mem_in;
    } beat_t;

    logic         clk = 1'b0;
    logic         areset_n = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] pc, icount;
    logic         busy, halted;
    logic [2:0]   dbg_state;

    logic         tb_we = 1'b0;
    logic [W-1:0] tb_waddr = '0;
    logic [W-1:0] tb_wdata = '0;
    logic [W-1:0] mem [256];

    int errors = 0;
    int checks = 0;

    subleq_mem_if #(.W(W)) bus ();

    subleq_control #(.W(W), .START_PC(START_PC), .HALT_ADDR(HALT_ADDR)) dut (
        .clk(clk), .areset_n(areset_n), .start(start), .stop(stop), .mem(bus),
        .pc(pc), .busy(busy), .halted(halted), .icount(icount), .dbg_state(dbg_state)
    );

    // clock / memory
    always #5 clk = ~clk;

    assign bus.mem_out = mem[bus.addr];

    always @(posedge clk) begin
        if (bus.store) mem[bus.addr] <= bus.mem_in;
        else if (tb_we) mem[tb_waddr] <= tb_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: instruction-level SUBLEQ plus expected bus beats
    logic [W-1:0] ref_mem [256];
    beat_t        exp_q [$];
    bit           model_on = 0;
    bit           running = 0;
    bit           m_halted = 0;
    logic [W-1:0] m_pc = '0;
    logic [W-1:0] m_icount = '0;
    logic [W-1:0] m_b, m_r, m_npc;

    task automatic build_instr();
        logic [W-1:0] ia, ib, ic, res;
        ia  = ref_mem[m_pc];
        ib  = ref_mem[W'(m_pc + 8'd1)];
        ic  = ref_mem[W'(m_pc + 8'd2)];
        res = ref_mem[ib] - ref_mem[ia];
        m_b   = ib;
        m_r   = res;
        m_npc = ($signed(res) <= 0) ? ic : W'(m_pc + 8'd3);
        exp_q.push_back('{1'b1, 1'b0, m_pc, 8'h00});
        exp_q.push_back('{1'b1, 1'b0, W'(m_pc + 8'd1), 8'h00});
        exp_q.push_back('{1'b1, 1'b0, W'(m_pc + 8'd2), 8'h00});
        exp_q.push_back('{1'b1, 1'b0, ia, 8'h00});
        exp_q.push_back('{1'b1, 1'b0, ib, 8'h00});
        exp_q.push_back('{1'b0, 1'b1, ib, res});
    endtask

    always @(negedge clk) begin
        beat_t bt;
        if (!areset_n) begin
            model_on = 1;
            check("reset_store", {31'b0, bus.store}, 32'd0);
            running  = 0;
            m_halted = 0;
            m_pc     = START_PC;
            m_icount = '0;
            exp_q.delete();
        end else begin
            if (tb_we) ref_mem[tb_waddr] = tb_wdata;
            if (model_on) begin
                bt = '0;
                if (running) begin
                    if (exp_q.size() == 0) build_instr();
                    bt = exp_q.pop_front();
                end
                check("load",   {31'b0, bus.load},  {31'b0, bt.load});
                check("store",  {31'b0, bus.store}, {31'b0, bt.store});
                check("addr",   {24'b0, bus.addr},  {24'b0, bt.addr});
                check("mem_in", {24'b0, bus.mem_in}, {24'b0, bt.mem_in});
                check("pc",     {24'b0, pc},        {24'b0, m_pc});
                check("icount", {24'b0, icount},    {24'b0, m_icount});
                check("busy",   {31'b0, busy},      {31'b0, running});
                check("halted", {31'b0, halted},    {31'b0, m_halted});
                if (running && bt.store) begin
                    ref_mem[m_b] = m_r;
                    m_pc     = m_npc;
                    m_icount = m_icount + 8'd1;
                    if (m_npc == HALT_ADDR || stop) begin
                        running  = 0;
                        m_halted = 1;
                    end
                end else if (!running && start) begin
                    running  = 1;
                    m_halted = 0;
                    m_pc     = START_PC;
                    m_icount = '0;
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        tick();
        areset_n = 1'b1;
    endtask

    task automatic poke(input logic [W-1:0] a, input logic [W-1:0] d);
        tb_we = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 256; i++) poke(W'(i), rnd ? W'($urandom_range(0, 255)) : 8'h00);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        do_reset();
        check("rst_pc", {24'b0, pc}, 32'h00);
        check("rst_icount", {24'b0, icount}, 32'h00);
        check("rst_busy", {31'b0, busy | halted}, 32'd0);

        // 1: mem[4] = 5 - 7 = -2, branch to 6
        fill_mem(0);
        poke(0, 3); poke(1, 4); poke(2, 6); poke(3, 7); poke(4, 5);
        stop = 1'b1;
        pulse_start();
        repeat (6) tick();
        check("t1_mem4", {24'b0, mem[4]}, 32'hFE);
        check("t1_pc", {24'b0, pc}, 32'h06);
        check("t1_icount", {24'b0, icount}, 32'h01);
        check("t1_halted", {31'b0, halted}, 32'd1);
        stop = 1'b0;

        // 2: exact bus sequence, 9 - 2 = 7 not leq
        do_reset();
        fill_mem(0);
        poke(0, 8'h10); poke(1, 8'h11); poke(2, 8'h20); poke(8'h10, 2); poke(8'h11, 9);
        stop = 1'b1;
        pulse_start();
        begin
            logic [W-1:0] seq [5];
            seq = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11};
            for (int i = 0; i < 5; i++) begin
                check("t2_load", {31'b0, bus.load}, 32'd1);
                check("t2_addr", {24'b0, bus.addr}, {24'b0, seq[i]});
                tick();
            end
        end
        check("t2_store", {31'b0, bus.store}, 32'd1);
        check("t2_saddr", {24'b0, bus.addr}, 32'h11);
        check("t2_mem_in", {24'b0, bus.mem_in}, 32'h07);
        tick();
        check("t2_pc", {24'b0, pc}, 32'h03);
        stop = 1'b0;

        // 3: A==B, branch to the halt address
        do_reset();
        fill_mem(0);
        poke(0, 8'h12); poke(1, 8'h12); poke(2, 8'hFF); poke(8'h12, 8'h55);
        pulse_start();
        wait_idle(20);
        check("t3_mem", {24'b0, mem[8'h12]}, 32'h00);
        check("t3_halted", {31'b0, halted}, 32'd1);
        check("t3_pc", {24'b0, pc}, 32'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_quiet", {30'b0, bus.load, bus.store}, 32'd0);
        end

        // 4: stop during FETCH_B of the third instruction, then restarts
        do_reset();
        fill_mem(0);
        for (int k = 0; k < 6; k++) begin
            poke(W'(3 * k), 8'h40); poke(W'(3 * k + 1), 8'h41); poke(W'(3 * k + 2), 8'h00);
        end
        poke(8'h40, 1); poke(8'h41, 100);
        pulse_start();
        repeat (13) tick();
        stop = 1'b1;
        wait_idle(20);
        check("t4_icount", {24'b0, icount}, 32'h03);
        check("t4_halted", {31'b0, halted}, 32'd1);
        check("t4_pc", {24'b0, pc}, 32'h09);
        check("t4_mem", {24'b0, mem[8'h41]}, 32'd97);
        stop = 1'b0;
        pulse_start();
        check("t4_restart_ic", {24'b0, icount}, 32'h00);
        check("t4_restart_pc", {24'b0, pc}, 32'h00);
        stop = 1'b1;
        wait_idle(20);
        check("t4_one_instr", {24'b0, icount}, 32'h01);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_ss_busy", {31'b0, busy}, 32'd1);
        wait_idle(20);
        check("t4_ss_icount", {24'b0, icount}, 32'h01);
        check("t4_ss_pc", {24'b0, pc}, 32'h03);
        check("t4_ss_mem", {24'b0, mem[8'h41]}, 32'd95);
        stop = 1'b0;

        // 5: start ignored mid-run, reset during WRITE suppresses the store
        do_reset();
        pulse_start();
        repeat (2) tick();
        pulse_start();
        repeat (2) tick();
        check("t5_write_addr", {24'b0, bus.addr}, 32'h41);
        areset_n = 1'b0;
        #1;
        check("t5_no_store", {31'b0, bus.store}, 32'd0);
        tick();
        areset_n = 1'b1;
        check("t5_idle", {30'b0, busy, halted}, 32'd0);
        check("t5_pc", {24'b0, pc}, 32'h00);
        check("t5_mem", {24'b0, mem[8'h41]}, 32'd95);

        // 6: instruction straddling the top of memory
        do_reset();
        fill_mem(0);
        poke(0, 8'h30); poke(1, 8'h30); poke(2, 8'hFE);
        poke(8'hFE, 8'h50); poke(8'hFF, 8'h51); poke(8'h30, 7);
        poke(8'h50, 1); poke(8'h51, 5);
        pulse_start();
        repeat (6) tick();
        check("t6_pc", {24'b0, pc}, 32'hFE);
        check("t6_a0", {24'b0, bus.addr}, 32'hFE);
        tick();
        check("t6_a1", {24'b0, bus.addr}, 32'hFF);
        tick();
        check("t6_a2", {24'b0, bus.addr}, 32'h00);
        stop = 1'b1;
        wait_idle(20);
        check("t6_npc", {24'b0, pc}, 32'h01);
        check("t6_mem", {24'b0, mem[8'h51]}, 32'h04);
        check("t6_icount", {24'b0, icount}, 32'h02);
        stop = 1'b0;

        // random programs with random start/stop/reset
        for (int run = 0; run < 3; run++) begin
            do_reset();
            fill_mem(1);
            for (int i = 0; i < 2000; i++) begin
                start    = ($urandom_range(0, 15) == 0);
                stop     = ($urandom_range(0, 40) == 0);
                areset_n = ($urandom_range(0, 400) != 0);
                tick();
            end
            start = 1'b0;
            areset_n = 1'b1;
            stop = 1'b1;
            wait_idle(20);
            stop = 1'b0;
            tick();
            for (int i = 0; i < 256; i++) check("rand_mem", {24'b0, mem[i]}, {24'b0, ref_mem[i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
